// File: rtl/pat_seq.sv
// pat_seq: parametrised pattern-buffer processor core.
// Executes {fptr, cond, fop, opc, imm} instructions fetched combinationally
// from external instruction memory at pc. It operates on an accumulator,
// internal data memory, a bounded call stack and an external field buffer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_in / pc              instruction fetch
//   field_req/fieldp/field_ack/field_in   field read handshake
//   field_we/fieldwp/field_out            registered field write strobe
//   halted, fault             core is in HALT / FAULT
module pat_seq #(
  parameter int I_ADR_W     = 10,
  parameter int D_W         = 8,
  parameter int DMEM_DEPTH  = 8,
  parameter int STACK_DEPTH = 8,
  parameter int FP_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FP_W+14:0]   imem_in,
  output logic [I_ADR_W-1:0] pc,
  output logic               field_req,
  output logic [FP_W-1:0]    fieldp,
  input  logic               field_ack,
  input  logic [D_W-1:0]     field_in,
  output logic               field_we,
  output logic [FP_W-1:0]    fieldwp,
  output logic [D_W-1:0]     field_out,
  output logic               halted,
  output logic               fault
);
  localparam int DA_W  = $clog2(DMEM_DEPTH);
  localparam int SA_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SA_W + 1;

  localparam logic [3:0] OP_BF = 4'h0, OP_BB = 4'h1, OP_CALL = 4'h2, OP_LDI = 4'h3,
                         OP_LDM = 4'h4, OP_STM = 4'h5, OP_SETSP = 4'h6, OP_RET = 4'h7,
                         OP_OR = 4'h8, OP_AND = 4'h9, OP_ADDM = 4'ha, OP_SUBM = 4'hb,
                         OP_ADD = 4'hc, OP_SUB = 4'hd, OP_HALT = 4'he, OP_I3 = 4'hf;
  localparam logic [3:0] I3_SHL = 4'h0, I3_SHR = 4'h1, I3_ASHR = 4'h2, I3_INCSP = 4'h3,
                         I3_DECSP = 4'h4, I3_NOT = 4'h5;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FWAIT = 2'd1, S_HALT = 2'd2, S_FAULT = 2'd3} state_e;
  state_e state_q, state_d;

  logic [I_ADR_W-1:0] pc_q, pc_d;
  logic [D_W-1:0]     acc_q, acc_d, sp_q, sp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d, c_q, c_d;
  logic               field_req_q, field_req_d, field_we_q, field_we_d;
  logic [FP_W-1:0]    fieldp_q, fieldp_d, fieldwp_q, fieldwp_d;
  logic [D_W-1:0]     field_out_q, field_out_d;

  logic [D_W-1:0]     dmem_q [DMEM_DEPTH];
  logic [I_ADR_W-1:0] stk_q  [STACK_DEPTH];
  logic               dmem_we, stk_we;

  // instruction fields
  logic [FP_W-1:0] fptr;
  logic [1:0]      cond;
  logic            fop;
  logic [3:0]      opc, sub;
  logic [7:0]      imm;
  logic [2:0]      amt;
  assign fptr = imem_in[FP_W+14:15];
  assign cond = imem_in[14:13];
  assign fop  = imem_in[12];
  assign opc  = imem_in[11:8];
  assign imm  = imem_in[7:0];
  assign sub  = imm[6:3];
  assign amt  = imm[2:0];

  logic [D_W-1:0]     imm_x, amt_x, opnd, bsrc, dmem_rd, res;
  logic [I_ADR_W-1:0] imm_a, pc_inc, stk_rd;
  logic cond_ok, alu2, i3_fld, rd_op, wr_op, needs_rd, go, flt, c_upd, c_new;

  assign imm_x   = D_W'(imm);
  assign amt_x   = D_W'(amt);
  assign imm_a   = I_ADR_W'(imm);
  assign pc_inc  = pc_q + 1'b1;
  assign dmem_rd = dmem_q[imm[DA_W-1:0]];
  assign stk_rd  = stk_q[SA_W'(cnt_q - 1'b1)];

  // decode: which ops read / write the operand location
  always_comb begin
    case (cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = z_q;
      2'b10:   cond_ok = c_q;
      default: cond_ok = !z_q;
    endcase
    alu2   = (opc >= OP_OR) && (opc <= OP_SUB);
    i3_fld = (opc == OP_I3) &&
             (sub == I3_SHL || sub == I3_SHR || sub == I3_ASHR || sub == I3_NOT);
    rd_op  = (opc == OP_STM) || alu2 || i3_fld;
    wr_op  = (opc == OP_LDI) || (opc == OP_LDM) || alu2 || i3_fld;
  end

  assign needs_rd = fop && rd_op;
  // go: the instruction completes this cycle (immediately, or on the ack)
  assign go   = (state_q == S_RUN && cond_ok && !needs_rd) ||
                (state_q == S_FWAIT && field_ack);
  assign opnd = (state_q == S_FWAIT) ? field_in : acc_q;
  assign flt  = go && ((opc == OP_CALL && cnt_q == CNT_W'(STACK_DEPTH)) ||
                       (opc == OP_RET  && cnt_q == '0));
  assign bsrc = (opc == OP_ADDM || opc == OP_SUBM) ? dmem_rd : imm_x;

  // ALU: result, plus carry update for add/sub and shifts
  always_comb begin
    res   = opnd;
    c_new = c_q;
    c_upd = 1'b0;
    case (opc)
      OP_LDI:          res = imm_x;
      OP_LDM:          res = dmem_rd;
      OP_OR:           res = opnd | imm_x;
      OP_AND:          res = opnd & imm_x;
      OP_ADDM, OP_ADD: begin {c_new, res} = {1'b0, opnd} + {1'b0, bsrc}; c_upd = 1'b1; end
      OP_SUBM, OP_SUB: begin {c_new, res} = {1'b0, opnd} - {1'b0, bsrc}; c_upd = 1'b1; end
      OP_I3: begin
        // an extra guard bit catches the last bit shifted out; amt=0 keeps C
        case (sub)
          I3_SHL:  begin {c_new, res} = {1'b0, opnd} << amt;           c_upd = (amt != 3'd0); end
          I3_SHR:  begin {res, c_new} = {opnd, 1'b0} >> amt;           c_upd = (amt != 3'd0); end
          I3_ASHR: begin {res, c_new} = $signed({opnd, 1'b0}) >>> amt; c_upd = (amt != 3'd0); end
          I3_NOT:  res = ~opnd;
          default: res = opnd;
        endcase
      end
      default: res = opnd;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (cond_ok) begin
          if (needs_rd)            state_d = S_FWAIT;
          else if (flt)            state_d = S_FAULT;
          else if (opc == OP_HALT) state_d = S_HALT;
        end
      end
      S_FWAIT: if (field_ack) state_d = S_RUN;
      default: state_d = state_q;
    endcase
  end

  // datapath next values
  always_comb begin
    pc_d        = pc_q;
    acc_d       = acc_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    c_d         = c_q;
    field_req_d = field_req_q;
    fieldp_d    = fieldp_q;
    field_we_d  = 1'b0;
    fieldwp_d   = fieldwp_q;
    field_out_d = field_out_q;
    dmem_we     = 1'b0;
    stk_we      = 1'b0;
    if (state_q == S_RUN && !cond_ok) begin
      pc_d = pc_inc;
    end else if (state_q == S_RUN && needs_rd) begin
      field_req_d = 1'b1;
      fieldp_d    = fptr;
    end else if (go && !flt) begin
      field_req_d = 1'b0;
      pc_d        = pc_inc;
      case (opc)
        OP_BF:    pc_d = pc_q + imm_a;
        OP_BB:    pc_d = pc_q - imm_a;
        OP_CALL:  begin stk_we = 1'b1; cnt_d = cnt_q + 1'b1; pc_d = pc_q + imm_a; end
        OP_RET:   begin cnt_d = cnt_q - 1'b1; pc_d = stk_rd; end
        OP_HALT:  pc_d = pc_q;
        OP_STM:   dmem_we = 1'b1;
        OP_SETSP: sp_d = imm_x;
        OP_I3: begin
          if (sub == I3_INCSP)      sp_d = sp_q + amt_x;
          else if (sub == I3_DECSP) sp_d = sp_q - amt_x;
        end
        default: ;
      endcase
      if (wr_op) begin
        if (fop) begin
          field_we_d  = 1'b1;
          fieldwp_d   = fptr;
          field_out_d = res;
        end else begin
          acc_d = res;
        end
        z_d = (res == '0);
      end
      if (c_upd) c_d = c_new;
    end
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == S_HALT);
    fault  = (state_q == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      acc_q       <= '0;
      sp_q        <= '0;
      cnt_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      field_req_q <= 1'b0;
      fieldp_q    <= '0;
      field_we_q  <= 1'b0;
      fieldwp_q   <= '0;
      field_out_q <= '0;
    end else begin
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      c_q         <= c_d;
      field_req_q <= field_req_d;
      fieldp_q    <= fieldp_d;
      field_we_q  <= field_we_d;
      fieldwp_q   <= fieldwp_d;
      field_out_q <= field_out_d;
    end
  end

  // memories are not reset; contents only become defined through stm / call
  always_ff @(posedge clk) begin
    if (!rst && dmem_we) dmem_q[imm[DA_W-1:0]] <= opnd;
    if (!rst && stk_we)  stk_q[SA_W'(cnt_q)]   <= pc_inc;
  end

  assign pc        = pc_q;
  assign field_req = field_req_q;
  assign fieldp    = fieldp_q;
  assign field_we  = field_we_q;
  assign fieldwp   = fieldwp_q;
  assign field_out = field_out_q;
endmodule
